// File: rtl/pwm_receiver_array.sv
// pwm_receiver_array: multi-channel RC PWM capture with plausibility check, saturating mapping and loss-of-signal failsafe.
module pwm_receiver_array #(
  parameter int NUM_CHANNELS  = 6,
  parameter int VAL_WIDTH     = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int MIN_PULSE_US  = 1000,
  parameter int PULSE_SHIFT   = 2,
  parameter int REJECT_MIN_US = 800,
  parameter int REJECT_MAX_US = 2500,
  parameter int TIMEOUT_US    = 25000,
  parameter int FAILSAFE_VAL  = 0
) (
  input  logic                              us_clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           pwm_in,
  output logic [NUM_CHANNELS*VAL_WIDTH-1:0] value_out,
  output logic [NUM_CHANNELS-1:0]           update_strobe,
  output logic [NUM_CHANNELS-1:0]           channel_valid,
  output logic                              all_valid
);
  typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH} state_t;
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] REJ_MIN   = CNT_WIDTH'(REJECT_MIN_US);
  localparam logic [CNT_WIDTH-1:0] REJ_MAX   = CNT_WIDTH'(REJECT_MAX_US);
  localparam logic [CNT_WIDTH-1:0] HI_SAT    = CNT_WIDTH'(REJECT_MAX_US + 1);
  localparam logic [CNT_WIDTH-1:0] MIN_PULSE = CNT_WIDTH'(MIN_PULSE_US);
  localparam logic [CNT_WIDTH-1:0] TMO       = CNT_WIDTH'(TIMEOUT_US);
  localparam logic [CNT_WIDTH-1:0] TMO_M1    = CNT_WIDTH'(TIMEOUT_US - 1);
  localparam logic [VAL_WIDTH-1:0] SAFE      = VAL_WIDTH'(FAILSAFE_VAL);
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || VAL_WIDTH >= CNT_WIDTH || TIMEOUT_US < 1 ||
      longint'(TIMEOUT_US) >= (longint'(1) << CNT_WIDTH) ||
      longint'(REJECT_MAX_US) + 1 >= (longint'(1) << CNT_WIDTH)) begin : g_bad_params
    $error("pwm_receiver_array: CNT_WIDTH too narrow or parameter out of range");
  end
  // Synchronisers read 0 for two cycles after reset; hold WAIT_LOW until they carry real samples.
  logic [1:0] settle;
  always_ff @(posedge us_clk) settle <= reset ? 2'b00 : {settle[0], 1'b1};
  always_ff @(posedge us_clk) all_valid <= reset ? 1'b0 : &channel_valid;
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic s1, s2, s3, rise, fall, accept, expire;
    state_t state, state_nxt;
    logic [CNT_WIDTH-1:0] hi_cnt, to_cnt, shifted;
    logic [VAL_WIDTH-1:0] val, mapped;
    always_ff @(posedge us_clk)
      {s3, s2, s1} <= reset ? 3'b000 : {s2, s1, pwm_in[i]};
    always_ff @(posedge us_clk)
      state <= reset ? WAIT_LOW : state_nxt;
    always_comb
      state_nxt = (state == WAIT_LOW) ? ((settle[1] && !s2) ? ARMED : WAIT_LOW) :
                  (state == ARMED)    ? (rise ? HIGH : ARMED) :
                  (state == HIGH)     ? (fall ? ARMED : HIGH) : WAIT_LOW;
    always_comb begin
      rise    = s2 & ~s3;
      fall    = ~s2 & s3;
      accept  = (state == HIGH) && fall && (hi_cnt >= REJ_MIN) && (hi_cnt <= REJ_MAX);
      expire  = to_cnt >= TMO_M1;
      shifted = (hi_cnt - MIN_PULSE) >> PULSE_SHIFT;
      mapped  = (hi_cnt < MIN_PULSE) ? '0 : (|(shifted >> VAL_WIDTH)) ? '1 : shifted[VAL_WIDTH-1:0];
    end
    always_ff @(posedge us_clk)
      if (reset) hi_cnt <= '0;
      else if (state == ARMED && rise) hi_cnt <= ONE;
      else if (state == HIGH && s2 && hi_cnt != HI_SAT) hi_cnt <= hi_cnt + ONE;
    always_ff @(posedge us_clk)
      if (reset || accept) to_cnt <= '0;
      else if (to_cnt != TMO) to_cnt <= to_cnt + ONE;
    // An accept landing on the expiry cycle wins, so the channel never blinks invalid.
    always_ff @(posedge us_clk)
      if (reset) begin
        val              <= SAFE;
        channel_valid[i] <= 1'b0;
        update_strobe[i] <= 1'b0;
      end else begin
        update_strobe[i] <= accept;
        if (accept) begin
          val              <= mapped;
          channel_valid[i] <= 1'b1;
        end else if (expire) begin
          val              <= SAFE;
          channel_valid[i] <= 1'b0;
        end
      end
    assign value_out[i*VAL_WIDTH +: VAL_WIDTH] = val;
  end
endmodule

// File: tb/tb_pwm_receiver_array.sv
// tb_pwm_receiver_array: directed pulses with per-channel scoreboard queues drained by a strobe monitor.
module tb_pwm_receiver_array;
  localparam int N = 6, VW = 8, TMO = 25000;
  logic us_clk = 1'b0, reset;
  logic [N-1:0] pwm;
  logic [N*VW-1:0] value_out;
  logic [N-1:0] update_strobe, channel_valid;
  logic all_valid;
  int n_chk = 0, n_fail = 0;
  longint cyc = 0;
  typedef struct {int v; longint c;} exp_t;
  exp_t exp_q[N][$];

  pwm_receiver_array dut (
    .us_clk(us_clk), .reset(reset), .pwm_in(pwm), .value_out(value_out),
    .update_strobe(update_strobe), .channel_valid(channel_valid), .all_valid(all_valid)
  );

  always #5 us_clk = ~us_clk;
  always @(posedge us_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  function automatic int val(input int ch);
    return int'(value_out[ch*VW +: VW]);
  endfunction

  task automatic gap(input int n);
    repeat (n) @(negedge us_clk);
  endtask

  task automatic wait_cyc(input longint c);
    while (cyc < c) @(negedge us_clk);
  endtask

  // Called on a negedge: w posedges sample high, strobe expected 3 cycles after the fall.
  task automatic pulse(input int ch, input int w, input int e, output longint sc);
    pwm[ch] = 1'b1;
    repeat (w) @(negedge us_clk);
    pwm[ch] = 1'b0;
    sc = cyc + 3;
    if (e >= 0) exp_q[ch].push_back('{v: e, c: sc});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge us_clk);
      if (!reset)
        for (int i = 0; i < N; i++) begin
          if (update_strobe[i]) begin
            if (exp_q[i].size() == 0) chk($sformatf("unexpected_strobe_ch%0d", i), update_strobe[i], 0);
            else begin
              e = exp_q[i].pop_front();
              chk($sformatf("strobe_cycle_ch%0d", i), cyc, e.c);
              chk($sformatf("strobe_value_ch%0d", i), val(i), e.v);
              chk($sformatf("strobe_valid_ch%0d", i), channel_valid[i], 1);
            end
          end else if (exp_q[i].size() != 0 && exp_q[i][0].c < cyc) begin
            e = exp_q[i].pop_front();
            chk($sformatf("missing_strobe_ch%0d", i), update_strobe[i], 1);
          end
        end
    end
  endtask

  initial begin
    longint d, db, dc, e0, e2, e3, e4, s, d0, d1, d2, d3, d4, d5;
    reset = 1'b1;
    pwm = '0;
    pwm[3] = 1'b1;
    fork monitor(); join_none
    gap(5);
    chk("reset_value_out", value_out, 0);
    chk("reset_strobe", update_strobe, 0);
    chk("reset_valid", channel_valid, 0);
    chk("reset_all_valid", all_valid, 0);
    reset = 1'b0;
    fork
      begin
        gap(1500);
        pwm[3] = 1'b0;
        gap(50);
        pulse(0, 1500, 125, e0);
        wait_cyc(e0);
        chk("ch0_value", val(0), 125);
        chk("valid_ch5_3_1_0", {channel_valid[5], channel_valid[3], channel_valid[1], channel_valid[0]}, 4'b0001);
        chk("values_ch1_3_5_failsafe", val(1) + val(3) + val(5), 0);
        gap(300); pulse(1, 1000, 0, d);
        gap(300); pulse(1, 2000, 250, d);
        gap(300); pulse(1, 2100, 255, d);
        gap(300); pulse(1, 950, 0, d);
        gap(300); pulse(3, 1800, 200, e3);
        wait_cyc(e3);
        chk("ch3_after_reset_pulse", val(3), 200);
      end
      begin
        gap(200);  pulse(2, 1200, 50, e2);
        gap(300);  pulse(2, 700, -1, db);
        gap(300);  pulse(2, 2600, -1, db);
        gap(300);  pulse(2, 5000, -1, db);
        gap(300);
        wait_cyc(e2 + TMO - 1);
        chk("ch2_valid_before_timeout", channel_valid[2], 1);
        chk("ch2_value_held", val(2), 50);
        gap(1);
        chk("ch2_valid_after_timeout", channel_valid[2], 0);
        chk("ch2_value_failsafe", val(2), 0);
      end
      begin
        gap(300);
        pulse(4, 1500, 125, e4);
        wait_cyc(e4 + TMO - 3 - 2000);
        pulse(4, 2000, 250, dc);
        wait_cyc(e4 + TMO - 1);
        chk("ch4_valid_pre_expiry", channel_valid[4], 1);
        chk("ch4_old_value", val(4), 125);
        gap(1);
        chk("ch4_valid_at_expiry", channel_valid[4], 1);
        chk("ch4_new_value", val(4), 250);
        gap(1);
        chk("ch4_valid_post_expiry", channel_valid[4], 1);
      end
    join
    gap(10);
    s = cyc;
    for (int f = 0; f < 2; f++) begin
      wait_cyc(s + 20000 * f);
      fork
        pulse(0, 1000, 0, d0);
        pulse(1, 1200, 50, d1);
        pulse(2, 1400, 100, d2);
        pulse(3, 1600, 150, d3);
        pulse(4, 1800, 200, d4);
        pulse(5, 2000, 250, d5);
      join
      wait_cyc(s + 20000 * f + 2003);
      chk("frame_channel_valid", channel_valid, 6'h3f);
      if (f == 0) chk("all_valid_lags_last_lane", all_valid, 0);
      gap(1);
      chk("frame_all_valid", all_valid, 1);
    end
    gap(10);
    for (int i = 0; i < N; i++) chk($sformatf("queue_drained_ch%0d", i), exp_q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
